i8255_bus_master: RTL

//  Synchronous bus initiator generating 8255-style CPU bus cycles (cs_n, rd_n, wr_n, a, d) toward a PPI peripheral.

---
 rtl/i8255_bus_master_pkg.sv | 34 +++
 rtl/i8255_bus_master_if.sv | 35 +++
 rtl/i8255_bus_master_phase_timer.sv | 38 +++
 rtl/i8255_bus_master.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/i8255_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i8255_pkg
// Brief   : Shared addresses, FSM states and mode-word fields for the 8255 bus master.
// Revision: 1.0  initial release
// ============================================================================
package i8255_pkg;

  localparam logic [1:0] A_PA   = 2'b00;
  localparam logic [1:0] A_PB   = 2'b01;
  localparam logic [1:0] A_PC   = 2'b10;
  localparam logic [1:0] A_CTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam int MODE_SET = 7;
  localparam int PA_IN    = 4;
  localparam int PCH_IN   = 3;
  localparam int PB_IN    = 1;
  localparam int PCL_IN   = 0;

  // Phase timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [3:0] phase_load(input int cyc);
    return 4'(cyc - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i8255_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module  : i8255_bus_master_if
// Brief   : Request/response handshake and 8255 CPU-bus signals of the bus master.
// Revision: 1.0  initial release
// ============================================================================
interface i8255_bus_master_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] a;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, d_in,
    output req_ready, rsp_valid, rsp_rdata, cs_n, rd_n, wr_n, a, d_out, d_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, d_in,
    input  req_ready, rsp_valid, rsp_rdata, cs_n, rd_n, wr_n, a, d_out, d_oe
  );

endinterface
`default_nettype wire

// File: rtl/i8255_bus_master_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : i8255_phase_timer
// Brief   : Loadable 4-bit down-counter; 'last' flags the final cycle of a phase.
// Revision: 1.0  initial release
// ============================================================================
module i8255_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/i8255_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : i8255_bus_master
// Brief   : Turns valid/ready register requests into timed 8255 read/write cycles.
//           Define I8255M_INIT_EN to write INIT_MODE to the control port after reset.
// Revision: 1.0  initial release
// ============================================================================
module i8255_bus_master
  import i8255_pkg::*;
#(
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 3,
  parameter int         HOLD_CYC   = 1,
  parameter logic [7:0] INIT_MODE  = 8'h80
) (
  input  logic                  clk,
  input  logic                  reset,
  i8255_bus_master_if.master    bus
);

  localparam logic [3:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = phase_load(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = phase_load(HOLD_CYC);

`ifdef I8255M_INIT_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t     state_q, state_d;
  logic       write_q, write_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       init_q, init_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic [1:0] a_q, a_d;
  logic [7:0] d_out_q, d_out_d;
  logic       d_oe_q, d_oe_d;

  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_last;
  logic       accept;
  logic       active;

  i8255_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    init_d      = init_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tmr_load    = 1'b0;
    tmr_val     = SETUP_LD;
    accept      = bus.req_valid & req_ready_q & (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = bus.req_write;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          init_d   = 1'b0;
          tmr_load = 1'b1;
          state_d  = SETUP;
        end
      end
      INIT: begin
        write_d  = 1'b1;
        addr_d   = A_CTRL;
        wdata_d  = INIT_MODE;
        init_d   = 1'b1;
        tmr_load = 1'b1;
        state_d  = SETUP;
      end
      SETUP: begin
        if (tmr_last) begin
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        if (tmr_last) begin
          if (!write_q) begin
            rsp_rdata_d = bus.d_in;
          end
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (tmr_last) begin
          rsp_valid_d = ~init_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus pins are registered from the next state so they change in step with the FSM.
    active      = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d      = ~active;
    rd_n_d      = ~((state_d == STROBE) && !write_d);
    wr_n_d      = ~((state_d == STROBE) && write_d);
    a_d         = active ? addr_d : a_q;
    d_out_d     = (active && write_d) ? wdata_d : d_out_q;
    d_oe_d      = active && write_d;
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      write_q     <= 1'b0;
      addr_q      <= 2'b00;
      wdata_q     <= 8'h00;
      init_q      <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      a_q         <= 2'b00;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      init_q      <= init_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      a_q         <= a_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.wr_n      = wr_n_q;
  assign bus.a         = a_q;
  assign bus.d_out     = d_out_q;
  assign bus.d_oe      = d_oe_q;

endmodule
`default_nettype wire
